// File: rtl/pc_ctrl_pkg.sv
// Shared decode constants for the next-PC controller and the fetch stage.
// Opcodes, PC-select encodings, instruction field positions and the branch-offset sign extension.
package pc_ctrl_pkg;

  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;

  typedef enum logic [1:0] {
    PC_NPC    = 2'b00,
    PC_JUMP   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_RETURN = 2'b11
  } pc_src_t;

  localparam int OPCODE_LSB = 12;
  localparam int RS_LSB     = 9;
  localparam int RT_LSB     = 6;
  localparam int IMM6_W     = 6;
  localparam int JIMM_W     = 12;

  function automatic logic [15:0] sext6(input logic [IMM6_W-1:0] imm);
    return {{(16-IMM6_W){imm[IMM6_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// and a pop on an empty stack leaves all state unchanged.
module return_address_stack #(
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] data_in,
  output logic [15:0] top_data,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic        underflow
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [15:0]   entries [RAS_DEPTH];
  logic [PW-1:0] top_ptr;
  logic [CW-1:0] count;

  assign empty     = (count == '0);
  assign full      = (count == CW'(RAS_DEPTH));
  assign overflow  = push & full;
  assign underflow = pop & empty;
  assign top_data  = empty ? 16'h0000 : entries[top_ptr - PW'(1)];

  // top_ptr points at the next free slot; power-of-two depth makes the wrap free
  always_ff @(posedge clk) begin
    if (reset) begin
      top_ptr <= '0;
      count   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= 16'h0000;
    end else if (push) begin
      entries[top_ptr] <= data_in;
      top_ptr          <= top_ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      top_ptr <= top_ptr - PW'(1);
      count   <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_control_unit.sv
// Decode-stage next-PC controller: resolves jumps, calls, returns and branches,
// and squashes the single wrong-path fetch that follows every taken redirect.
module pc_control_unit
  import pc_ctrl_pkg::*;
#(
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [15:0] instruction,
  input  logic [15:0] id_NPC,
  input  logic [15:0] rs_data,
  input  logic [15:0] rt_data,
  output logic [1:0]  PCsrc,
  output logic [15:0] I_TypeImmediate,
  output logic [15:0] J_TypeImmediate,
  output logic [15:0] ReturnAddress,
  output logic        flush,
  output logic        ras_underflow,
  output logic        ras_overflow
);

  logic        squash;
  logic        eff_valid;
  logic [3:0]  opcode;
  pc_src_t     pc_src;
  logic        push;
  logic        pop;
  logic [15:0] ras_top;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_udf;

  assign opcode    = instruction[OPCODE_LSB +: 4];
  assign eff_valid = id_valid & ~squash & ~reset;

  assign I_TypeImmediate = id_NPC + sext6(instruction[IMM6_W-1:0]);
  assign J_TypeImmediate = {id_NPC[15:JIMM_W], instruction[JIMM_W-1:0]};

  always_comb begin
    pc_src = PC_NPC;
    push   = 1'b0;
    pop    = 1'b0;
    if (eff_valid) begin
      unique case (opcode)
        OP_JMP:  pc_src = PC_JUMP;
        OP_CALL: begin
          pc_src = PC_JUMP;
          push   = 1'b1;
        end
        OP_RET: begin
          pc_src = PC_RETURN;
          pop    = 1'b1;
        end
        OP_BEQ:  pc_src = (rs_data == rt_data) ? PC_BRANCH : PC_NPC;
        OP_BNE:  pc_src = (rs_data != rt_data) ? PC_BRANCH : PC_NPC;
        default: pc_src = PC_NPC;
      endcase
    end
  end

  assign PCsrc = pc_src;
  assign flush = (pc_src != PC_NPC);

  // The squash bit kills exactly the one instruction fetched behind a redirect
  always_ff @(posedge clk) begin
    if (reset) squash <= 1'b0;
    else       squash <= flush;
  end

  return_address_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .data_in   (id_NPC),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_ovf),
    .underflow (ras_udf)
  );

  assign ReturnAddress = reset ? 16'h0000 : ras_top;
  assign ras_overflow  = ras_ovf & ras_full;
  assign ras_underflow = ras_udf & ras_empty;

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit: literal expectations per scenario plus a
// queue-based reference model compared against the outputs on every cycle.
module tb_pc_control_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic [15:0] id_NPC = 16'h0000;
  logic [15:0] rs_data = 16'h0000;
  logic [15:0] rt_data = 16'h0000;
  logic [1:0]  PCsrc;
  logic [15:0] I_TypeImmediate;
  logic [15:0] J_TypeImmediate;
  logic [15:0] ReturnAddress;
  logic        flush;
  logic        ras_underflow;
  logic        ras_overflow;

  int vectors = 0;
  int miscompares = 0;

  pc_control_unit #(.RAS_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .instruction     (instruction),
    .id_NPC          (id_NPC),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .PCsrc           (PCsrc),
    .I_TypeImmediate (I_TypeImmediate),
    .J_TypeImmediate (J_TypeImmediate),
    .ReturnAddress   (ReturnAddress),
    .flush           (flush),
    .ras_underflow   (ras_underflow),
    .ras_overflow    (ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [15:0] ins,
                               input logic [15:0] npc, input logic [15:0] rs, input logic [15:0] rt);
    @(posedge clk);
    #1;
    reset = rst; id_valid = v; instruction = ins; id_NPC = npc; rs_data = rs; rt_data = rt;
    @(negedge clk);
  endtask

  function automatic logic [15:0] mk_i(input logic [3:0] op, input logic [5:0] imm);
    return {op, 3'd1, 3'd2, imm};
  endfunction

  function automatic logic [15:0] mk_j(input logic [3:0] op, input logic [11:0] j);
    return {op, j};
  endfunction

  // Reference model: the stack is a plain queue, newest entry at the back
  logic [15:0] m_ras[$];
  bit          m_squash = 1'b0;

  always begin : model_compare
    logic [1:0]  e_pc;
    logic [15:0] e_i, e_j, e_ra;
    logic        e_push, e_pop, e_ovf, e_udf, live;
    logic [3:0]  op;
    @(negedge clk);
    op     = instruction[15:12];
    live   = id_valid && !m_squash && !reset;
    e_i    = id_NPC + {{10{instruction[5]}}, instruction[5:0]};
    e_j    = {id_NPC[15:12], instruction[11:0]};
    e_ra   = (reset || m_ras.size() == 0) ? 16'h0000 : m_ras[m_ras.size()-1];
    e_pc   = 2'b00;
    e_push = 1'b0;
    e_pop  = 1'b0;
    if (live) begin
      if (op == 4'hC) e_pc = 2'b01;
      else if (op == 4'hD) begin e_pc = 2'b01; e_push = 1'b1; end
      else if (op == 4'hE) begin e_pc = 2'b11; e_pop = 1'b1; end
      else if (op == 4'hA && rs_data == rt_data) e_pc = 2'b10;
      else if (op == 4'hB && rs_data != rt_data) e_pc = 2'b10;
    end
    e_ovf = e_push && m_ras.size() == DEPTH;
    e_udf = e_pop && m_ras.size() == 0;
    checkOutput("model PCsrc", {14'b0, PCsrc}, {14'b0, e_pc});
    checkOutput("model I_Type", I_TypeImmediate, e_i);
    checkOutput("model J_Type", J_TypeImmediate, e_j);
    checkOutput("model ReturnAddress", ReturnAddress, e_ra);
    checkOutput("model flush", {15'b0, flush}, {15'b0, e_pc != 2'b00});
    checkOutput("model overflow", {15'b0, ras_overflow}, {15'b0, e_ovf});
    checkOutput("model underflow", {15'b0, ras_underflow}, {15'b0, e_udf});
    if (reset) begin
      m_ras.delete();
      m_squash = 1'b0;
    end else begin
      m_squash = (e_pc != 2'b00);
      if (e_push) begin
        m_ras.push_back(id_NPC);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      if (e_pop && m_ras.size() > 0) void'(m_ras.pop_back());
    end
  end

  localparam logic [15:0] NOP = 16'h0000;

  initial begin
    // Reset, including a valid RET presented while reset is high
    applyStimulus(1, 1, mk_j(4'hE, 12'h000), 16'h1234, 0, 0);
    checkOutput("reset PCsrc", {14'b0, PCsrc}, 16'h0000);
    checkOutput("reset flush", {15'b0, flush}, 16'h0000);
    checkOutput("reset ReturnAddress", ReturnAddress, 16'h0000);
    checkOutput("reset underflow", {15'b0, ras_underflow}, 16'h0000);

    // JMP then a squashed taken-looking BEQ
    applyStimulus(0, 1, mk_j(4'hC, 12'h0A5), 16'h3011, 0, 0);
    checkOutput("jmp PCsrc", {14'b0, PCsrc}, 16'h0001);
    checkOutput("jmp target", J_TypeImmediate, 16'h30A5);
    checkOutput("jmp flush", {15'b0, flush}, 16'h0001);
    applyStimulus(0, 1, mk_i(4'hA, 6'h04), 16'h3012, 7, 7);
    checkOutput("squashed beq PCsrc", {14'b0, PCsrc}, 16'h0000);
    checkOutput("squashed beq flush", {15'b0, flush}, 16'h0000);

    // BEQ taken with negative offset, then not taken
    applyStimulus(0, 1, mk_i(4'hA, 6'b111110), 16'h0010, 5, 5);
    checkOutput("beq taken PCsrc", {14'b0, PCsrc}, 16'h0002);
    checkOutput("beq target", I_TypeImmediate, 16'h000E);
    applyStimulus(0, 1, NOP, 16'h0011, 0, 0);
    applyStimulus(0, 1, mk_i(4'hA, 6'b111110), 16'h0010, 5, 6);
    checkOutput("beq not taken PCsrc", {14'b0, PCsrc}, 16'h0000);
    checkOutput("beq not taken flush", {15'b0, flush}, 16'h0000);

    // BNE taken and not taken
    applyStimulus(0, 1, mk_i(4'hB, 6'h03), 16'h0100, 1, 2);
    checkOutput("bne taken PCsrc", {14'b0, PCsrc}, 16'h0002);
    checkOutput("bne target", I_TypeImmediate, 16'h0103);
    applyStimulus(0, 1, NOP, 16'h0101, 0, 0);
    applyStimulus(0, 1, mk_i(4'hB, 6'h03), 16'h0100, 9, 9);
    checkOutput("bne not taken PCsrc", {14'b0, PCsrc}, 16'h0000);

    // CALL / RET pair, then the stack is empty again
    applyStimulus(0, 1, mk_j(4'hD, 12'h100), 16'h0021, 0, 0);
    checkOutput("call PCsrc", {14'b0, PCsrc}, 16'h0001);
    applyStimulus(0, 1, NOP, 16'h0022, 0, 0);
    applyStimulus(0, 1, mk_j(4'hE, 12'h000), 16'h0101, 0, 0);
    checkOutput("ret PCsrc", {14'b0, PCsrc}, 16'h0003);
    checkOutput("ret address", ReturnAddress, 16'h0021);
    applyStimulus(0, 1, NOP, 16'h0102, 0, 0);
    applyStimulus(0, 1, mk_j(4'hE, 12'h000), 16'h0022, 0, 0);
    checkOutput("ret empty underflow", {15'b0, ras_underflow}, 16'h0001);
    checkOutput("ret empty address", ReturnAddress, 16'h0000);
    applyStimulus(0, 1, NOP, 16'h0000, 0, 0);

    // Five nested CALLs overflow a four-deep stack
    for (int n = 1; n <= 5; n++) begin
      applyStimulus(0, 1, mk_j(4'hD, 12'h200), 16'(n), 0, 0);
      checkOutput("nested call overflow", {15'b0, ras_overflow}, (n == 5) ? 16'h0001 : 16'h0000);
      applyStimulus(0, 1, NOP, 16'h0200, 0, 0);
    end
    for (int n = 5; n >= 2; n--) begin
      applyStimulus(0, 1, mk_j(4'hE, 12'h000), 16'h0300, 0, 0);
      checkOutput("nested ret address", ReturnAddress, 16'(n));
      checkOutput("nested ret underflow", {15'b0, ras_underflow}, 16'h0000);
      applyStimulus(0, 1, NOP, 16'h0301, 0, 0);
    end
    applyStimulus(0, 1, mk_j(4'hE, 12'h000), 16'h0300, 0, 0);
    checkOutput("fifth ret underflow", {15'b0, ras_underflow}, 16'h0001);
    checkOutput("fifth ret address", ReturnAddress, 16'h0000);
    checkOutput("fifth ret PCsrc", {14'b0, PCsrc}, 16'h0003);
    applyStimulus(0, 1, NOP, 16'h0001, 0, 0);

    // Reset in the middle of a call chain discards the stack
    applyStimulus(0, 1, mk_j(4'hD, 12'h300), 16'h0007, 0, 0);
    applyStimulus(0, 1, NOP, 16'h0301, 0, 0);
    applyStimulus(0, 1, mk_j(4'hD, 12'h300), 16'h0008, 0, 0);
    applyStimulus(0, 1, NOP, 16'h0301, 0, 0);
    applyStimulus(1, 1, mk_j(4'hE, 12'h000), 16'h0302, 0, 0);
    checkOutput("mid reset PCsrc", {14'b0, PCsrc}, 16'h0000);
    checkOutput("mid reset ReturnAddress", ReturnAddress, 16'h0000);
    applyStimulus(0, 1, mk_j(4'hE, 12'h000), 16'h0302, 0, 0);
    checkOutput("post reset ret underflow", {15'b0, ras_underflow}, 16'h0001);
    checkOutput("post reset ret address", ReturnAddress, 16'h0000);
    applyStimulus(0, 1, NOP, 16'h0000, 0, 0);

    // A bubble carrying a RET opcode must not touch the stack
    applyStimulus(0, 1, mk_j(4'hD, 12'h400), 16'h0044, 0, 0);
    applyStimulus(0, 1, NOP, 16'h0401, 0, 0);
    applyStimulus(0, 0, mk_j(4'hE, 12'h000), 16'h0401, 0, 0);
    checkOutput("bubble ret PCsrc", {14'b0, PCsrc}, 16'h0000);
    checkOutput("bubble ret flush", {15'b0, flush}, 16'h0000);
    applyStimulus(0, 1, mk_j(4'hE, 12'h000), 16'h0402, 0, 0);
    checkOutput("after bubble ret address", ReturnAddress, 16'h0044);
    checkOutput("after bubble ret PCsrc", {14'b0, PCsrc}, 16'h0003);

    // Mixed traffic checked only by the model
    for (int k = 0; k < 60; k++) begin
      logic [3:0] ops [6];
      logic [3:0] o;
      ops[0] = 4'hC; ops[1] = 4'hD; ops[2] = 4'hE; ops[3] = 4'hA; ops[4] = 4'hB; ops[5] = 4'h3;
      o = ops[$urandom_range(0, 5)];
      applyStimulus(0, ($urandom_range(0, 3) != 0), {o, 12'($urandom)}, 16'($urandom),
                    16'($urandom_range(0, 2)), 16'($urandom_range(0, 2)));
    end

    applyStimulus(0, 0, NOP, 16'h0000, 0, 0);
    applyStimulus(0, 0, NOP, 16'h0000, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
